// File: rtl/pipeline_ctrl.sv
// Central back-end pipeline controller: turns per-stage stall requests into
// the pause vector, sequences exception flush and the frontend redirect
// handshake, and tracks stall statistics plus a stall watchdog.
module pipeline_ctrl #(
    parameter int unsigned STAGES     = 8,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] pause_req_i,
    input  logic              exc_valid_i,
    input  logic [ADDR_W-1:0] exc_target_i,
    input  logic              redirect_ready_i,
    output logic [STAGES-1:0] pause_o,
    output logic              exception_flush_o,
    output logic              redirect_valid_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [31:0]       stall_cycles_o,
    output logic              watchdog_o
);

    localparam int unsigned STALL_W = 32;
    localparam int unsigned WDOG_W  = 16;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'(WDOG_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_W-1:0]    target_q, target_d;
    logic [STALL_W-1:0]   stall_q, stall_d;
    logic [WDOG_W-1:0]    wcnt_q, wcnt_d;
    logic                 wdog_q, wdog_d;
    logic [STAGES-1:0]    base;
    logic                 req_any;

    // Stall propagates backwards: a request at stage k pauses stages 0..k.
    always_comb begin
        base = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            base[i] = |(pause_req_i >> i);
        end
    end

    assign req_any = |pause_req_i;

    // State, captured redirect target, counters and sticky watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
            stall_q  <= '0;
            wcnt_q   <= '0;
            wdog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            stall_q  <= stall_d;
            wcnt_q   <= wcnt_d;
            wdog_q   <= wdog_d;
        end
    end

    // Next-state, target capture and per-state pause/flush/redirect outputs.
    always_comb begin
        state_d           = state_q;
        target_d          = target_q;
        pause_o           = base;
        exception_flush_o = 1'b0;
        redirect_valid_o  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (exc_valid_i) begin
                    target_d = exc_target_i;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Flush cycle: every register bubbles, new exceptions ignored.
                pause_o           = '0;
                exception_flush_o = 1'b1;
                state_d           = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                // Hold the pc stage until the frontend takes the new address.
                pause_o          = base | STAGES'(1);
                redirect_valid_o = 1'b1;
                if (exc_valid_i) begin
                    target_d = exc_target_i;
                    state_d  = ST_FLUSH;
                end else if (redirect_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating stall-cycle counter and watchdog run-length counter.
    always_comb begin
        stall_d = stall_q;
        wcnt_d  = '0;
        wdog_d  = wdog_q;
        if (state_q == ST_RUN && req_any) begin
            if (stall_q != '1) begin
                stall_d = stall_q + STALL_W'(1);
            end
            wcnt_d = (wcnt_q >= WDOG_MAX) ? WDOG_MAX : wcnt_q + WDOG_W'(1);
        end
        if (wcnt_d == WDOG_MAX) begin
            wdog_d = 1'b1;
        end
    end

    assign redirect_pc_o  = target_q;
    assign stall_cycles_o = stall_q;
    assign watchdog_o     = wdog_q;

endmodule
